// File: rtl/tx_8b10b_encoder.sv
// -----------------------------------------------------------------------------
// tx_8b10b_encoder
//
// Per-byte 8b/10b encoder for the PIPE TX datapath. It takes the scrambler's
// 32-bit data, per-byte K flags and valid, and encodes 1, 2 or 4 bytes per pclk
// according to PIPEWIDTH. Running disparity (RD) is chained across the active
// byte lanes and carried across cycles. The 10-bit symbols are registered, so
// the latency is one pclk.
//
// Stream handshake: this is a valid-only stream with no backpressure.
//   - A word is accepted on every rising pclk edge where encDataValid = 1 and
//     PIPEWIDTH is legal.
//   - The encoded word appears on encSymOut with encSymValid = 1 after that
//     edge.
//   - Any other cycle yields encSymValid = 0 and encSymOut = 0, and RD is held.
//
// Parameters
//   RD_INIT        RD loaded by reset (0 = RD-, 1 = RD+)
//
// Ports
//   pclk           in   1   PIPE clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   PIPEWIDTH      in   6   8 / 16 / 32 bits per cycle; other values are idle
//   encDataIn      in   32  bytes to encode, byte0 = [7:0]
//   encDataK       in   4   per-byte control flag
//   encDataValid   in   1   input qualifier
//   encSymOut      out  40  symbol n = [10n+9:10n], bit 10n+9 is 'a'
//   encSymValid    out  1   output qualifier
//   encRd          out  1   current RD register
//   encKErr        out  1   only when ENC_KERR_CHECK_EN is defined: an active
//                           lane carried an unsupported K code
//
// Build option
//   ENC_KERR_CHECK_EN   adds the registered encKErr flag. An unsupported K code
//                       is replaced by K28.5 whether or not the macro is defined.
// -----------------------------------------------------------------------------
module tx_8b10b_encoder #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [31:0] encDataIn,
    input  logic [3:0]  encDataK,
    input  logic        encDataValid,
    output logic [39:0] encSymOut,
    output logic        encSymValid,
    output logic        encRd
`ifdef ENC_KERR_CHECK_EN
    ,
    output logic        encKErr
`endif
);

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
    } enc_t;

    // 5b/6b code in RD- form, output order abcdei.
    function automatic logic [5:0] code6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b data code (primary x.7) in RD- form, output order fghj.
    function automatic logic [3:0] code4d_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // 3b/4b control code in RD- form. The RD+ form is always the complement.
    function automatic logic [3:0] code4k_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    // The supported control codes are K28.0-7, K23.7, K27.7, K29.7 and K30.7.
    function automatic logic k_legal(input logic [7:0] b);
        logic [4:0] x;
        logic [2:0] y;
        x = b[4:0];
        y = b[7:5];
        return (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                (x == 5'd29) || (x == 5'd30)));
    endfunction

    function automatic enc_t encode_byte(input logic [7:0] b, input logic k,
                                         input logic rd_in);
        enc_t       r;
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid;
        logic       use_a7;
        x = b[4:0];
        y = b[7:5];
        // An unsupported K code is sent as K28.5.
        if (k && !k_legal(b)) begin
            x = 5'd28;
            y = 3'd5;
        end
        c6 = (k && (x == 5'd28)) ? 6'b001111 : code6_neg(x);
        // Unbalanced codes, and D.7 (111000/000111), take their RD+ form
        // as the complement.
        if (rd_in && (($countones(c6) != 3) || (x == 5'd7)))
            c6 = ~c6;
        rd_mid = rd_in ^ ($countones(c6) != 3);
        if (k) begin
            c4 = code4k_neg(y);
            if (rd_mid)
                c4 = ~c4;
        end else begin
            // Alternate x.7 form avoids a run of five equal bits across the
            // sub-block boundary.
            use_a7 = (y == 3'd7) &&
                     ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                      ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
            c4 = use_a7 ? 4'b0111 : code4d_neg(y);
            if (rd_mid && (($countones(c4) != 2) || (y == 3'd3)))
                c4 = ~c4;
        end
        r.sym = {c6, c4};
        r.rd  = rd_mid ^ ($countones(c4) != 2);
        return r;
    endfunction

    logic [3:0]  lane_en;
    logic        take;
    logic [39:0] sym_d;
    logic        rd_d;
    logic [39:0] sym_q;
    logic        valid_q;
    logic        rd_q;

    // Lanes are always a contiguous group starting at lane 0. An empty mask
    // marks an illegal width.
    always_comb begin
        lane_en = 4'b0000;
        case (PIPEWIDTH)
            6'd8:    lane_en = 4'b0001;
            6'd16:   lane_en = 4'b0011;
            6'd32:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    assign take = encDataValid && (lane_en != 4'b0000);

    // RD ripples lane to lane. Inactive lanes pass RD through untouched, so
    // rd_d ends up as the last active lane's ending RD.
    always_comb begin
        enc_t e;
        logic rd_run;
        sym_d  = '0;
        rd_run = rd_q;
        e      = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                e = encode_byte(encDataIn[8*i +: 8], encDataK[i], rd_run);
                sym_d[10*i +: 10] = e.sym;
                rd_run = e.rd;
            end
        end
        rd_d = rd_run;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            sym_q   <= '0;
            valid_q <= 1'b0;
            rd_q    <= RD_INIT;
        end else begin
            sym_q   <= take ? sym_d : 40'd0;
            valid_q <= take;
            if (take)
                rd_q <= rd_d;
        end
    end

    assign encSymOut   = sym_q;
    assign encSymValid = valid_q;
    assign encRd       = rd_q;

`ifdef ENC_KERR_CHECK_EN
    logic kerr_d;
    logic kerr_q;

    always_comb begin
        kerr_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i] && encDataK[i] && !k_legal(encDataIn[8*i +: 8]))
                kerr_d = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset)
            kerr_q <= 1'b0;
        else
            kerr_q <= take && kerr_d;
    end

    assign encKErr = kerr_q;
`endif

endmodule

// File: tb/tb_tx_8b10b_encoder.sv
module tb_tx_8b10b_encoder;

    localparam int W = 43;  // {kerr, rd, valid, sym[39:0]}

    logic        pclk;
    logic        reset;
    logic [5:0]  PIPEWIDTH;
    logic [31:0] encDataIn;
    logic [3:0]  encDataK;
    logic        encDataValid;
    logic [39:0] encSymOut;
    logic        encSymValid;
    logic        encRd;
`ifdef ENC_KERR_CHECK_EN
    logic        encKErr;
`endif

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic driving_done = 1'b0;

    tx_8b10b_encoder #(.RD_INIT(1'b0)) dut (
        .pclk         (pclk),
        .reset        (reset),
        .PIPEWIDTH    (PIPEWIDTH),
        .encDataIn    (encDataIn),
        .encDataK     (encDataK),
        .encDataValid (encDataValid),
        .encSymOut    (encSymOut),
        .encSymValid  (encSymValid),
        .encRd        (encRd)
`ifdef ENC_KERR_CHECK_EN
        ,
        .encKErr      (encKErr)
`endif
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard compare ----------------
    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per sampled edge, compared on the falling edge.
    always @(negedge pclk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sym",   encSymOut,          e[39:0]);
            check("valid", {39'd0, encSymValid}, {39'd0, e[40]});
            check("rd",    {39'd0, encRd},       {39'd0, e[41]});
`ifdef ENC_KERR_CHECK_EN
            check("kerr",  {39'd0, encKErr},     {39'd0, e[42]});
`endif
        end else if (encSymValid === 1'b1) begin
            check("unexpected_valid", {39'd0, encSymValid}, 40'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [5:0] w, input logic [31:0] d,
                        input logic [3:0] k, input logic v,
                        input logic [39:0] es, input logic ev, input logic erd,
                        input logic ek);
        reset        = r;
        PIPEWIDTH    = w;
        encDataIn    = d;
        encDataK     = k;
        encDataValid = v;
        @(posedge pclk);
        exp_q.push_back({ek, erd, ev, es});
        #1;
    endtask

    function automatic logic [39:0] syms(input logic [9:0] s3, input logic [9:0] s2,
                                         input logic [9:0] s1, input logic [9:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    initial begin
        // Reset wins over a valid word.
        step(1, 6'd32, 32'hBCBC_BCBC, 4'hF, 1, 40'd0, 0, 0, 0);
        step(1, 6'd32, 32'hBCBC_BCBC, 4'hF, 1, 40'd0, 0, 0, 0);

        // K28.5 alternating RD at width 8.
        step(0, 6'd8, 32'h0000_00BC, 4'h1, 1, syms(0, 0, 0, 10'h0FA), 1, 1, 0);
        step(0, 6'd8, 32'h0000_00BC, 4'h1, 1, syms(0, 0, 0, 10'h305), 1, 0, 0);

        // D0.0 from RD-, then from RD+.
        step(0, 6'd8, 32'h0000_0000, 4'h0, 1, syms(0, 0, 0, 10'h274), 1, 0, 0);
        step(0, 6'd8, 32'h0000_00BC, 4'h1, 1, syms(0, 0, 0, 10'h0FA), 1, 1, 0);
        step(0, 6'd8, 32'h0000_0000, 4'h0, 1, syms(0, 0, 0, 10'h18B), 1, 1, 0);

        // Width 32, mixed lanes starting at RD+: D0.0, K28.5, D21.5, D0.0.
        step(0, 6'd32, 32'h00B5_BC00, 4'h2, 1,
             syms(10'h274, 10'h2AA, 10'h305, 10'h18B), 1, 0, 0);

        // Width 32, four K28.5 from RD-.
        step(0, 6'd32, 32'hBCBC_BCBC, 4'hF, 1,
             syms(10'h305, 10'h0FA, 10'h305, 10'h0FA), 1, 0, 0);

        // Width 16: D21.5 x2, upper lanes zero.
        step(0, 6'd16, 32'hFFFF_B5B5, 4'h0, 1, syms(0, 0, 10'h2AA, 10'h2AA), 1, 0, 0);

        // Width 16: illegal K codes in inactive lanes are ignored.
        step(0, 6'd16, 32'h0000_BCBC, 4'hF, 1, syms(0, 0, 10'h305, 10'h0FA), 1, 0, 0);

        // Valid gap holds RD+.
        step(0, 6'd8, 32'h0000_00BC, 4'h1, 1, syms(0, 0, 0, 10'h0FA), 1, 1, 0);
        for (int i = 0; i < 3; i++)
            step(0, 6'd8, 32'h0000_00BC, 4'h1, 0, 40'd0, 0, 1, 0);
        step(0, 6'd8, 32'h0000_0000, 4'h0, 1, syms(0, 0, 0, 10'h18B), 1, 1, 0);

        // Illegal width with valid behaves as idle.
        step(0, 6'd24, 32'h0000_0000, 4'h1, 1, 40'd0, 0, 1, 0);

        // Reset mid-stream.
        step(1, 6'd8, 32'h0000_00BC, 4'h1, 1, 40'd0, 0, 0, 0);

        // Illegal K (K0.0) at RD- becomes K28.5 and flags an error.
        step(0, 6'd8, 32'h0000_0000, 4'h1, 1, syms(0, 0, 0, 10'h0FA), 1, 1, 1);
        step(0, 6'd8, 32'h0000_0000, 4'h0, 1, syms(0, 0, 0, 10'h18B), 1, 1, 0);

        // x.7 forms: D11.7 at RD+ (A7), D17.7 at RD- (A7), D0.7 at RD+ (P7).
        step(0, 6'd8, 32'h0000_00EB, 4'h0, 1, syms(0, 0, 0, 10'h348), 1, 0, 0);
        step(0, 6'd8, 32'h0000_00F1, 4'h0, 1, syms(0, 0, 0, 10'h237), 1, 1, 0);
        step(0, 6'd8, 32'h0000_00E0, 4'h0, 1, syms(0, 0, 0, 10'h18E), 1, 1, 0);

        // K28.7 and K23.7 at RD+.
        step(0, 6'd8, 32'h0000_00FC, 4'h1, 1, syms(0, 0, 0, 10'h307), 1, 1, 0);
        step(0, 6'd8, 32'h0000_00F7, 4'h1, 1, syms(0, 0, 0, 10'h057), 1, 1, 0);

        // Trailing idle.
        step(0, 6'd8, 32'h0000_0000, 4'h0, 0, 40'd0, 0, 1, 0);

        driving_done = 1'b1;
    end

    // ---------------- final report ----------------
    initial begin
        int budget;
        budget = 0;
        while (!driving_done && budget < 1000) begin
            @(posedge pclk);
            budget++;
        end
        if (!driving_done)
            check("drive_timeout", {39'd0, driving_done}, 40'd1);
        @(negedge pclk);
        #1;
        check("queue_drained", 40'(exp_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
